// File: rtl/sample_pkt_pkg.sv
// Shared definitions for the I/Q sample packet format (decoder and encoder).
// Packet: SYNC0, SYNC1, seq, PAYLOAD_BYTES payload bytes, checksum.
package sample_pkt_pkg;

  localparam logic [7:0]  SYNC0           = 8'hA5;
  localparam logic [7:0]  SYNC1           = 8'h5A;
  localparam int unsigned PAYLOAD_BYTES   = 252;
  localparam int unsigned SAMPLES_PER_PKT = 84;
  localparam int unsigned PKT_BYTES       = 256;
  localparam int unsigned SAMPLE_W        = 12;

  typedef enum logic [2:0] {
    S_hunt0,
    S_hunt1,
    S_seq,
    S_payload,
    S_check
  } dec_state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] i;
    logic [SAMPLE_W-1:0] q;
  } iq_sample_t;

  // Three wire bytes, MSB first: b0=I[11:4], b1={I[3:0],Q[11:8]}, b2=Q[7:0].
  function automatic iq_sample_t unpack_sample(input logic [7:0] b0,
                                               input logic [7:0] b1,
                                               input logic [7:0] b2);
    iq_sample_t s;
    s.i = {b0, b1[7:4]};
    s.q = {b1[3:0], b2};
    return s;
  endfunction

endpackage

// File: rtl/sample_unpacker.sv
// Collects three payload bytes into one 24-bit {I,Q} sample.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (also clears held sample)
//   clr         - synchronous clear of the partial sample only
//   byte_stb    - payload byte valid
//   byte_idx    - byte position within the sample (0..2)
//   byte_data   - payload byte
//   sample_stb  - one-cycle pulse, registered, after the third byte
//   sample      - last completed sample, held until the next sample_stb
module sample_unpacker
  import sample_pkt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       byte_stb,
  input  logic [1:0] byte_idx,
  input  logic [7:0] byte_data,
  output logic       sample_stb,
  output iq_sample_t sample
);

  logic [7:0] b0;
  logic [7:0] b1;

  always_ff @(posedge clk) begin
    sample_stb <= 1'b0;
    if (rst) begin
      b0     <= '0;
      b1     <= '0;
      sample <= '0;
    end else if (clr) begin
      b0 <= '0;
      b1 <= '0;
    end else if (byte_stb) begin
      case (byte_idx)
        2'd0: b0 <= byte_data;
        2'd1: b1 <= byte_data;
        2'd2: begin
          sample     <= unpack_sample(b0, b1, byte_data);
          sample_stb <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sample_packet_decoder.sv
// Byte-stream decoder for I/Q sample packets: sync hunt, sequence tracking,
// sample unpacking, optional checksum and inter-byte timeout.
// Optional feature macro: SAMPLE_DECODER_CHECKSUM_EN (checksum check on o_pkt_err).
// Ports:
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_stb, i_data       - received byte strobe and data
//   o_sample_stb        - decoded sample valid pulse
//   o_sample_i/q        - sample components, held between strobes
//   o_pkt_done          - end of complete packet pulse
//   o_pkt_err           - checksum failure, with o_pkt_done
//   o_seq_gap           - sequence discontinuity, with o_pkt_done
//   o_timeout           - packet abandoned after TIMEOUT_CYCLES idle clocks
module sample_packet_decoder
  import sample_pkt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_stb,
  input  logic [7:0]          i_data,
  output logic                o_sample_stb,
  output logic [SAMPLE_W-1:0] o_sample_i,
  output logic [SAMPLE_W-1:0] o_sample_q,
  output logic                o_pkt_done,
  output logic                o_pkt_err,
  output logic                o_seq_gap,
  output logic                o_timeout
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  dec_state_e        state;
  logic [7:0]        byte_cnt;
  logic [1:0]        sub_idx;
  logic [IDLE_W-1:0] idle_cnt;
  logic [7:0]        cur_seq;
  logic [7:0]        prev_seq;
  logic              prev_valid;
  logic              timeout_hit_c;
  logic              unpack_clr_c;
  iq_sample_t        smp;

  // A byte arriving on the expiry cycle wins, so expiry requires !i_stb.
  assign timeout_hit_c = !i_stb && (state != S_hunt0) &&
                         (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign unpack_clr_c  = timeout_hit_c || (i_stb && (state == S_seq));

  // Packet framing FSM with idle timer and sequence tracking.
  always_ff @(posedge i_clk) begin
    o_pkt_done <= 1'b0;
    o_seq_gap  <= 1'b0;
    o_timeout  <= 1'b0;
    if (i_rst) begin
      state      <= S_hunt0;
      byte_cnt   <= '0;
      sub_idx    <= '0;
      idle_cnt   <= '0;
      cur_seq    <= '0;
      prev_seq   <= '0;
      prev_valid <= 1'b0;
    end else if (i_stb) begin
      idle_cnt <= '0;
      unique case (state)
        S_hunt0: if (i_data == SYNC0) state <= S_hunt1;
        S_hunt1: begin
          if (i_data == SYNC1)      state <= S_seq;
          else if (i_data != SYNC0) state <= S_hunt0;
        end
        S_seq: begin
          cur_seq  <= i_data;
          byte_cnt <= '0;
          sub_idx  <= '0;
          state    <= S_payload;
        end
        S_payload: begin
          sub_idx <= (sub_idx == 2'd2) ? 2'd0 : 2'(sub_idx + 2'd1);
          // Counter stops at the last index rather than wrapping.
          if (byte_cnt == 8'(PAYLOAD_BYTES - 1)) state <= S_check;
          else byte_cnt <= 8'(byte_cnt + 8'd1);
        end
        S_check: begin
          o_pkt_done <= 1'b1;
          o_seq_gap  <= prev_valid && (cur_seq != 8'(prev_seq + 8'd1));
          prev_seq   <= cur_seq;
          prev_valid <= 1'b1;
          state      <= S_hunt0;
        end
        default: state <= S_hunt0;
      endcase
    end else if (state != S_hunt0) begin
      if (timeout_hit_c) begin
        o_timeout <= 1'b1;
        idle_cnt  <= '0;
        state     <= S_hunt0;
      end else begin
        idle_cnt <= IDLE_W'(idle_cnt + IDLE_W'(1));
      end
    end
  end

  sample_unpacker u_unpacker (
    .clk        (i_clk),
    .rst        (i_rst),
    .clr        (unpack_clr_c),
    .byte_stb   (i_stb && (state == S_payload)),
    .byte_idx   (sub_idx),
    .byte_data  (i_data),
    .sample_stb (o_sample_stb),
    .sample     (smp)
  );

  assign o_sample_i = smp.i;
  assign o_sample_q = smp.q;

`ifdef SAMPLE_DECODER_CHECKSUM_EN
  logic [7:0] sum;
  logic       err_q;

  // Running sum of seq and payload; compared against the checksum byte.
  always_ff @(posedge i_clk) begin
    err_q <= 1'b0;
    if (i_rst) begin
      sum <= '0;
    end else if (i_stb) begin
      case (state)
        S_seq:     sum   <= i_data;
        S_payload: sum   <= 8'(sum + i_data);
        S_check:   err_q <= (i_data != sum);
        default: ;
      endcase
    end
  end

  assign o_pkt_err = err_q;
`else
  assign o_pkt_err = 1'b0;
`endif

endmodule
